dma_engine: RTL and testbench
=============================

Name: dma_engine

Overview:
- Parametrised successor to the fixed 256-byte sprite DMA in the CPU/APU chip top.
- A CPU write to a trigger address latches a source page. The block then stalls the CPU and copies XFER_LEN bytes from {page,00h}+idx to a fixed destination register.
- The transfer pauses under an external ready, reports progress, and pulses done on completion.
- Sits between the CPU core and the CPU memory bus; the top muxes a/d/r_nw while active_out is high.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- DST_ADDR, 16'h2004, destination address written for every byte.
- XFER_LEN, 256, bytes per transfer; legal range 1..256.
- CNT_W, 9, width of the progress counter; must satisfy 2**CNT_W > XFER_LEN.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- cpumc_a_in  in  16  CPU address bus
- cpumc_din_in  in  8  CPU write data; source page is taken from this on trigger
- cpumc_dout_in  in  8  memory read data returned to the CPU
- cpu_r_nw_in  in  1  CPU read/write (0 = write)
- rdy_in  in  1  external bus ready; low pauses the transfer
- active_out  out  1  DMA owns the bus; the top uses it to stall the CPU
- cpumc_a_out  out  16  DMA address
- cpumc_d_out  out  8  DMA write data
- cpumc_r_nw_out  out  1  DMA read/write
- count_out  out  CNT_W  bytes written so far in the current transfer
- done_out  out  1  one-cycle pulse after the last write

Clock and reset:
- One clock, clk_in.
- rst_in is synchronous and active-high.

Behaviour:
- Reset values: state IDLE, active_out 0, cpumc_a_out 0, cpumc_d_out 0, cpumc_r_nw_out 1, count_out 0, done_out 0, page 0, parity 0.
- Parity: a 1-bit cycle-parity flop toggles every clk_in edge while not in reset.
- Trigger: detected when state is IDLE, cpumc_a_in == TRIG_ADDR and cpu_r_nw_in == 0.
  - On the trigger edge: page <= cpumc_din_in, idx <= 0, count_out <= 0, state <= START.
- States:
  - IDLE: active_out 0.
  - START: one dummy cycle, active_out 1, r_nw 1, address held at DST_ADDR. Next state is ALIGN if the feature is enabled and parity==1, otherwise READ.
  - ALIGN: one dummy cycle, same outputs as START, then READ.
  - READ: cpumc_a_out = {page,8'h00} + idx, r_nw 1. cpumc_dout_in is sampled into the data register at the edge ending the cycle. Then WRITE.
  - WRITE: cpumc_a_out = DST_ADDR, cpumc_d_out = data register, r_nw 0. At the end of the cycle count_out increments.
    - If idx == XFER_LEN-1: state <= IDLE and done_out pulses on the following cycle.
    - Otherwise idx increments and state <= READ.
- Address arithmetic: 16-bit; {page,00h}+idx does not carry out of 16 bits. With XFER_LEN ≤ 256 it never leaves the page.
- Latency: the trigger write is in cycle T; active_out is high from T+1.
  - Without alignment: 1 + 2·XFER_LEN cycles (513 at the default).
  - With alignment: 514 cycles.
- rdy_in low:
  - In READ, WRITE or ALIGN, state, idx and the data register hold.
  - cpumc_r_nw_out is forced to 1 so no write occurs, and cpumc_a_out holds.
  - active_out stays 1.
  - START always advances regardless of rdy_in.
- Boundary and simultaneous events:
  - A trigger seen while not IDLE is ignored.
  - The trigger and done_out in the same cycle: done pulses; the trigger is accepted because state is IDLE.
  - With XFER_LEN=1: START, READ, WRITE, IDLE.
  - rst_in mid-transfer: returns to the reset values at the next edge. No partial write is issued after reset.
- count_out holds its final value after done until the next trigger.

Optional Feature:
- Macro: DMA_ODD_ALIGN_EN.
- Defined: the ALIGN state exists. A START entered with parity==1 inserts one extra dummy cycle, so transfer length depends on trigger parity (513 or 514 at the default), matching NES hardware.
- Undefined: ALIGN is never entered and the transfer is always 1 + 2·XFER_LEN cycles. The parity flop may be optimised away.

Decomposition:
- Package dma_pkg holds:
  - the state enum (IDLE, START, ALIGN, READ, WRITE);
  - the default TRIG_ADDR and DST_ADDR constants;
  - the NES OAM length constant 256.
- No sub-module; a single FSM plus counters.

Test Plan:
- Page load: write 8'h02 to 4014h on an even-parity cycle, XFER_LEN=256 → reads 0200h..02FFh alternate with writes to 2004h carrying the memory data; 513 active cycles; done_out pulses once; count_out == 256.
- Odd parity with DMA_ODD_ALIGN_EN defined → exactly 514 active cycles; first READ at T+3. With the macro undefined → 513 cycles.
- Pause: hold rdy_in low 5 cycles during the WRITE of byte 10 → no write while low; byte 10 written once after release; total active cycles +5.
- Reset mid-transfer: assert rst_in during READ of idx 100 → next cycle active_out 0, r_nw 1, count_out 0; a new trigger works normally.
- Edge cases: XFER_LEN=1, page 8'hFF → exactly one read at FF00h and one write to 2004h, 3 active cycles. A second write to 4014h during a transfer is ignored.
- Non-trigger traffic: CPU reads of 4014h and writes to 4015h → active_out stays 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the sprite/OAM DMA engine.
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] DEF_TRIG_ADDR = 16'h4014;
    localparam logic [15:0] DEF_DST_ADDR  = 16'h2004;
    localparam int          NES_OAM_LEN   = 256;

    // Source address inside the latched page; idx never exceeds 8'hFF so no carry out.
    function automatic logic [15:0] src_addr(input logic [7:0] page, input logic [7:0] idx);
        return {page, 8'h00} + {8'h00, idx};
    endfunction

endpackage

// File: rtl/dma_engine.sv
// Page-to-register DMA: a CPU write to TRIG_ADDR copies XFER_LEN bytes from {page,00h}+idx to DST_ADDR.
// Define DMA_ODD_ALIGN_EN to insert an extra dummy cycle for transfers triggered on an odd-parity cycle.
module dma_engine
    import dma_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = DEF_TRIG_ADDR,
    parameter logic [15:0] DST_ADDR  = DEF_DST_ADDR,
    parameter int          XFER_LEN  = NES_OAM_LEN,
    parameter int          CNT_W     = 9
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      cpumc_a_in,
    input  logic [7:0]       cpumc_din_in,
    input  logic [7:0]       cpumc_dout_in,
    input  logic             cpu_r_nw_in,
    input  logic             rdy_in,
    output logic             active_out,
    output logic [15:0]      cpumc_a_out,
    output logic [7:0]       cpumc_d_out,
    output logic             cpumc_r_nw_out,
    output logic [CNT_W-1:0] count_out,
    output logic             done_out
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t       r_state;
    logic             r_parity;
    logic [7:0]       r_page;
    logic [7:0]       r_idx;
    logic [7:0]       r_data;
    logic             r_active;
    logic [15:0]      r_a;
    logic             r_r_nw;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
`ifdef DMA_ODD_ALIGN_EN
    logic             r_align;
`endif

    logic w_trigger;

    assign w_trigger = (r_state == S_IDLE) && (cpumc_a_in == TRIG_ADDR) && !cpu_r_nw_in;

    // Transfer FSM with its address/data/progress registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_parity <= 1'b0;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_data   <= 8'h00;
            r_active <= 1'b0;
            r_a      <= 16'h0000;
            r_r_nw   <= 1'b1;
            r_count  <= '0;
            r_done   <= 1'b0;
`ifdef DMA_ODD_ALIGN_EN
            r_align  <= 1'b0;
`endif
        end else begin
            r_parity <= ~r_parity;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page   <= cpumc_din_in;
                        r_idx    <= 8'h00;
                        r_count  <= '0;
                        r_state  <= S_START;
                        r_active <= 1'b1;
                        r_a      <= DST_ADDR;
                        r_r_nw   <= 1'b1;
`ifdef DMA_ODD_ALIGN_EN
                        // Parity of the trigger cycle decides whether START is followed by ALIGN.
                        r_align  <= r_parity;
`endif
                    end
                end
                S_START: begin
`ifdef DMA_ODD_ALIGN_EN
                    if (r_align) begin
                        r_state <= S_ALIGN;
                    end else begin
                        r_state <= S_READ;
                        r_a     <= src_addr(r_page, r_idx);
                    end
`else
                    r_state <= S_READ;
                    r_a     <= src_addr(r_page, r_idx);
`endif
                end
                S_ALIGN: begin
                    if (rdy_in) begin
                        r_state <= S_READ;
                        r_a     <= src_addr(r_page, r_idx);
                    end
                end
                S_READ: begin
                    if (rdy_in) begin
                        r_data  <= cpumc_dout_in;
                        r_state <= S_WRITE;
                        r_a     <= DST_ADDR;
                        r_r_nw  <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (rdy_in) begin
                        r_count <= r_count + CNT_W'(1);
                        r_r_nw  <= 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state  <= S_IDLE;
                            r_done   <= 1'b1;
                            r_active <= 1'b0;
                            r_a      <= 16'h0000;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_READ;
                            r_a     <= src_addr(r_page, r_idx + 8'd1);
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                    r_r_nw   <= 1'b1;
                end
            endcase
        end
    end

    assign active_out     = r_active;
    assign cpumc_a_out    = r_a;
    assign cpumc_d_out    = r_data;
    // A stalled write must not reach the bus in the same cycle rdy drops, so rdy gates r_nw directly.
    assign cpumc_r_nw_out = r_r_nw | ~rdy_in;
    assign count_out      = r_count;
    assign done_out       = r_done;

endmodule

// File: tb/tb_dma_engine.sv
// Directed + randomized bench for dma_engine against a transfer-level reference model.
module tb_dma_engine;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DST  = 16'h2004;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_rnw;
    logic        rdy;
    logic [7:0]  mem_dout;
    logic        act;
    logic [15:0] dma_a;
    logic [7:0]  dma_d;
    logic        dma_rnw;
    logic [8:0]  cnt;
    logic        done;

    logic [15:0] cpu_a2;
    logic [7:0]  cpu_din2;
    logic        cpu_rnw2;
    logic        rdy2;
    logic [7:0]  mem_dout2;
    logic        act2;
    logic [15:0] dma_a2;
    logic [7:0]  dma_d2;
    logic        dma_rnw2;
    logic [8:0]  cnt2;
    logic        done2;

    logic [7:0]  key;
    logic [31:0] cyc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        logic [7:0] m;
        m = a[15:8] * 8'd29;
        return a[7:0] ^ m ^ key;
    endfunction

    assign mem_dout  = memf(dma_a);
    assign mem_dout2 = memf(dma_a2);

    // Cycle parity reference: zero on the reset edge, flips on every later edge.
    always @(posedge clk) begin
        if (rst_in) cyc <= 32'd0;
        else        cyc <= cyc + 32'd1;
    end

    dma_engine dut (
        .clk_in(clk), .rst_in(rst_in), .cpumc_a_in(cpu_a), .cpumc_din_in(cpu_din),
        .cpumc_dout_in(mem_dout), .cpu_r_nw_in(cpu_rnw), .rdy_in(rdy),
        .active_out(act), .cpumc_a_out(dma_a), .cpumc_d_out(dma_d),
        .cpumc_r_nw_out(dma_rnw), .count_out(cnt), .done_out(done)
    );

    dma_engine #(.XFER_LEN(1), .CNT_W(9)) dut1 (
        .clk_in(clk), .rst_in(rst_in), .cpumc_a_in(cpu_a2), .cpumc_din_in(cpu_din2),
        .cpumc_dout_in(mem_dout2), .cpu_r_nw_in(cpu_rnw2), .rdy_in(rdy2),
        .active_out(act2), .cpumc_a_out(dma_a2), .cpumc_d_out(dma_d2),
        .cpumc_r_nw_out(dma_rnw2), .count_out(cnt2), .done_out(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain, 1 random rdy, 2 rdy low 5 cycles on write of byte 10,
    //       3 reset during read of idx 100, 4 extra trigger writes mid-transfer
    task automatic run_xfer(input logic [7:0] page, input int mode, input logic want_odd);
        int          rd_idx = 0;
        int          wr_idx = 0;
        int          pauses = 0;
        int          active_cnt = 0;
        int          low_left = 0;
        int          align_exp = 0;
        bit          started = 0;
        bit          finished = 0;
        logic [15:0] base;
        base = {page, 8'h00};
        @(negedge clk);
        while (cyc[0] !== want_odd) @(negedge clk);
`ifdef DMA_ODD_ALIGN_EN
        align_exp = want_odd ? 1 : 0;
`endif
        cpu_a = TRIG; cpu_rnw = 1'b0; cpu_din = page; rdy = 1'b1;
        for (int c = 0; c < 2000 && !finished; c++) begin
            @(negedge clk);
            cpu_a = 16'h0000; cpu_rnw = 1'b1; cpu_din = 8'h00;
            if (mode == 4 && rd_idx == 5) begin
                cpu_a = TRIG; cpu_rnw = 1'b0; cpu_din = ~page;
            end
            if (low_left > 0) begin
                rdy = 1'b0;
                low_left--;
            end else if (mode == 1) begin
                rdy = ($urandom_range(3) != 0);
            end else begin
                rdy = 1'b1;
            end
            if (mode == 3 && rd_idx == 100 && wr_idx == 100) rst_in = 1'b1;
            #1;
            if (rst_in) begin
                chk("rst_read_addr", dma_a, base + 16'd100);
                @(negedge clk);
                rst_in = 1'b0;
                #1;
                chk("rst_active", act, 1'b0);
                chk("rst_rnw", dma_rnw, 1'b1);
                chk("rst_count", cnt, 32'd0);
                chk("rst_done", done, 1'b0);
                chk("rst_addr", dma_a, 16'h0000);
                finished = 1;
            end else if (act) begin
                active_cnt++;
                if (!started) begin
                    started = 1;
                    chk("start_rnw", dma_rnw, 1'b1);
                    chk("start_addr", dma_a, DST);
                end else if (!rdy) begin
                    pauses++;
                    chk("pause_rnw", dma_rnw, 1'b1);
                    if (mode == 2) chk("pause_addr", dma_a, DST);
                end else if (!dma_rnw) begin
                    chk("write_addr", dma_a, DST);
                    chk("write_data", dma_d, memf(base + 16'(wr_idx)));
                    chk("write_count", cnt, wr_idx);
                    wr_idx++;
                end else if (dma_a != DST) begin
                    chk("read_addr", dma_a, base + 16'(rd_idx));
                    rd_idx++;
                    if (mode == 2 && rd_idx == 11) low_left = 5;
                end
            end else if (started) begin
                finished = 1;
                chk("done_pulse", done, 1'b1);
                chk("final_count", cnt, 32'd256);
                chk("bytes_read", rd_idx, 256);
                chk("bytes_written", wr_idx, 256);
                chk("active_cycles", active_cnt, 1 + align_exp + 512 + pauses);
                if (mode == 2) chk("pause_cycles", pauses, 5);
                @(negedge clk);
                rdy = 1'b1;
                #1;
                chk("done_single", done, 1'b0);
                chk("count_hold", cnt, 32'd256);
            end else begin
                chk("active_after_trigger", act, 1'b1);
                finished = 1;
            end
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] pg;
        key = 8'($urandom);
        rst_in = 1'b1;
        cpu_a = 16'h0000; cpu_din = 8'h00; cpu_rnw = 1'b1; rdy = 1'b1;
        cpu_a2 = 16'h0000; cpu_din2 = 8'h00; cpu_rnw2 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_active", act, 1'b0);
        chk("reset_addr", dma_a, 16'h0000);
        chk("reset_data", dma_d, 8'h00);
        chk("reset_rnw", dma_rnw, 1'b1);
        chk("reset_count", cnt, 32'd0);
        chk("reset_done", done, 1'b0);
        @(negedge clk);
        rst_in = 1'b0;

        // CPU read of the trigger address and write of a neighbour never start a transfer.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_a = (i % 2 == 0) ? TRIG : 16'h4015;
            cpu_rnw = (i % 2 == 0) ? 1'b1 : 1'b0;
            cpu_din = 8'h55;
            #1;
            chk("nontrig_active", act, 1'b0);
        end
        @(negedge clk);
        cpu_a = 16'h0000; cpu_rnw = 1'b1;
        #1;
        chk("nontrig_active_after", act, 1'b0);

        // Single-byte instance, page FF, even-parity trigger.
        @(negedge clk);
        while (cyc[0] !== 1'b0) @(negedge clk);
        cpu_a2 = TRIG; cpu_rnw2 = 1'b0; cpu_din2 = 8'hFF;
        @(negedge clk);
        cpu_a2 = 16'h0000; cpu_rnw2 = 1'b1;
        #1;
        chk("len1_start_active", act2, 1'b1);
        chk("len1_start_rnw", dma_rnw2, 1'b1);
        @(negedge clk); #1;
        chk("len1_read_addr", dma_a2, 16'hFF00);
        chk("len1_read_rnw", dma_rnw2, 1'b1);
        @(negedge clk); #1;
        chk("len1_write_addr", dma_a2, DST);
        chk("len1_write_rnw", dma_rnw2, 1'b0);
        chk("len1_write_data", dma_d2, memf(16'hFF00));
        @(negedge clk); #1;
        chk("len1_idle", act2, 1'b0);
        chk("len1_done", done2, 1'b1);
        chk("len1_count", cnt2, 32'd1);

        run_xfer(8'h02, 0, 1'b0);
        pg = 8'($urandom_range(255)); if (pg == 8'h20) pg = 8'h21;
        run_xfer(pg, 0, 1'b1);
        run_xfer(8'h37, 2, 1'b0);
        run_xfer(8'h81, 3, 1'b0);
        run_xfer(8'h02, 0, 1'b0);
        pg = 8'($urandom_range(255)); if (pg == 8'h20) pg = 8'h21;
        run_xfer(pg, 4, 1'($urandom_range(1)));
        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom_range(255)); if (pg == 8'h20) pg = 8'h21;
            run_xfer(pg, 1, 1'($urandom_range(1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
